// File: rtl/word_deserializer.sv
// Rebuilds WORD_WIDTH-bit words from an MSB-first serial bit stream.
// A partial word is dropped, and frame_err is pulsed, when the gap between its bits grows too long.
module word_deserializer #(
  parameter int unsigned WORD_WIDTH  = 12,
  parameter int unsigned GAP_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic [3:0]            bit_count
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_MAX  = '1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [WORD_WIDTH-2:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [CNT_W-1:0]      gap_cnt, gap_nxt;
  logic [WORD_WIDTH-1:0] word_nxt;
  logic                  word_valid_nxt;
  logic                  frame_err_nxt;
  logic                  busy_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_count  <= '0;
      gap_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_count  <= cnt_nxt;
      gap_cnt    <= gap_nxt;
      word_out   <= word_nxt;
      word_valid <= word_valid_nxt;
      busy       <= busy_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift_reg;
    cnt_nxt        = bit_count;
    gap_nxt        = gap_cnt;
    word_nxt       = word_out;
    word_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    case (state)
      IDLE: begin
        gap_nxt = '0;
        if (bit_valid) begin
          shift_nxt = {{(WORD_WIDTH-2){1'b0}}, bit_in};
          cnt_nxt   = CNT_W'(1);
          state_nxt = SHIFT;
        end else begin
          cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          gap_nxt = '0;
          if (bit_count == LAST_BIT) begin
            word_nxt       = {shift_reg, bit_in};
            word_valid_nxt = 1'b1;
            cnt_nxt        = '0;
            state_nxt      = IDLE;
          end else begin
            shift_nxt = {shift_reg[WORD_WIDTH-3:0], bit_in};
            cnt_nxt   = bit_count + CNT_W'(1);
          end
        end else if (gap_cnt == GAP_LAST) begin
          // Stalled transmission: drop the partial word, keep word_out
          frame_err_nxt = 1'b1;
          shift_nxt     = '0;
          cnt_nxt       = '0;
          gap_nxt       = '0;
          state_nxt     = IDLE;
        end else if (gap_cnt != GAP_MAX) begin
          gap_nxt = gap_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == SHIFT);
  end

endmodule

// File: tb/tb_word_deserializer.sv
// Self-checking bench for word_deserializer: directed scenarios plus random streams,
// compared every cycle against a bit-queue reference model.
module tb_word_deserializer;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic [11:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        frame_err;
  logic [3:0]  bit_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: bits collected so far for the current word, and idle run length
  logic        m_q[$];
  int          m_idle;
  logic [11:0] m_word;
  logic        m_wv, m_fe, m_busy;
  logic [3:0]  m_cnt;

  word_deserializer #(.WORD_WIDTH(12), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .busy(busy),
    .frame_err(frame_err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic r, input logic v, input logic b);
    m_wv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_q.delete();
      m_idle = 0;
      m_word = 12'h000;
    end else if (v) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == 12) begin
        for (int i = 0; i < 12; i++) m_word[11-i] = m_q[i];
        m_wv = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == GAP) begin
        m_fe = 1'b1;
        m_q.delete();
        m_idle = 0;
      end
    end
    m_busy = (m_q.size() > 0);
    m_cnt  = 4'(m_q.size());
  endtask

  // Drive one cycle, let the edge happen, then advance the model
  task automatic step(input logic r, input logic v, input logic b);
    rst = r;
    bit_valid = v;
    bit_in = b;
    @(posedge clk);
    #1;
    cyc++;
    model_update(r, v, b);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({word_out, word_valid, busy, frame_err, bit_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset: got word=%h wv=%b busy=%b fe=%b cnt=%0d, need all 0",
               word_out, word_valid, busy, frame_err, bit_count);
    end
  endtask

  task automatic test_single();
    logic [11:0] w = 12'hA5C;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 11; i >= 0; i--) begin
      step(1'b0, 1'b1, w[i]);
      checks++;
      if ({word_valid, frame_err, busy, bit_count, word_out} !== {m_wv, m_fe, m_busy, m_cnt, m_word}) begin
        errors++;
        $display("FAIL single cyc=%0d: got wv=%b fe=%b busy=%b cnt=%0d word=%h need %b %b %b %0d %h",
                 cyc, word_valid, frame_err, busy, bit_count, word_out, m_wv, m_fe, m_busy, m_cnt, m_word);
      end
    end
    checks++;
    if (!(word_valid === 1'b1 && word_out === 12'hA5C && busy === 1'b0)) begin
      errors++;
      $display("FAIL single_word: got wv=%b word=%h busy=%b need 1 a5c 0", word_valid, word_out, busy);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: got wv=%b need 0", word_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] s = {12'hFFF, 12'h001};
    int p0 = -1, p1 = -1;
    logic [11:0] w0 = 12'h000, w1 = 12'h000;
    for (int i = 23; i >= -1; i--) begin
      if (i >= 0) step(1'b0, 1'b1, s[i]);
      else step(1'b0, 1'b0, 1'b0);
      checks++;
      if ({word_valid, frame_err, busy, bit_count, word_out} !== {m_wv, m_fe, m_busy, m_cnt, m_word}) begin
        errors++;
        $display("FAIL b2b cyc=%0d: got wv=%b fe=%b busy=%b cnt=%0d word=%h need %b %b %b %0d %h",
                 cyc, word_valid, frame_err, busy, bit_count, word_out, m_wv, m_fe, m_busy, m_cnt, m_word);
      end
      if (word_valid === 1'b1) begin
        if (p0 < 0) begin p0 = cyc; w0 = word_out; end
        else begin p1 = cyc; w1 = word_out; end
      end
    end
    checks++;
    if (!(p0 >= 0 && p1 - p0 == 12 && w0 === 12'hFFF && w1 === 12'h001)) begin
      errors++;
      $display("FAIL b2b_words: got spacing=%0d words=%h,%h need 12 fff,001", p1 - p0, w0, w1);
    end
  endtask

  // Send 5 bits of 12'h3C3, idle 'gap' cycles, then the rest when the word survives
  task automatic test_gap(input int gap);
    logic [11:0] w = 12'h3C3;
    logic [11:0] prev;
    logic        saw_fe = 1'b0;
    prev = word_out;
    for (int i = 11; i >= 7; i--) step(1'b0, 1'b1, w[i]);
    for (int k = 0; k < gap; k++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if ({word_valid, frame_err, busy, bit_count, word_out} !== {m_wv, m_fe, m_busy, m_cnt, m_word}) begin
        errors++;
        $display("FAIL gap%0d cyc=%0d: got wv=%b fe=%b busy=%b cnt=%0d word=%h need %b %b %b %0d %h",
                 gap, cyc, word_valid, frame_err, busy, bit_count, word_out, m_wv, m_fe, m_busy, m_cnt, m_word);
      end
      if (frame_err === 1'b1) saw_fe = 1'b1;
    end
    if (gap < GAP) begin
      for (int i = 6; i >= 0; i--) step(1'b0, 1'b1, w[i]);
      checks++;
      if (!(word_valid === 1'b1 && word_out === 12'h3C3 && !saw_fe)) begin
        errors++;
        $display("FAIL gap_ok: got wv=%b word=%h fe_seen=%b need 1 3c3 0", word_valid, word_out, saw_fe);
      end
    end else begin
      checks++;
      if (!(frame_err === 1'b1 && busy === 1'b0 && bit_count === 4'd0 && word_out === prev)) begin
        errors++;
        $display("FAIL gap_abort: got fe=%b busy=%b cnt=%0d word=%h need 1 0 0 %h",
                 frame_err, busy, bit_count, word_out, prev);
      end
      w = 12'h0F0;
      for (int i = 11; i >= 0; i--) begin
        step(1'b0, 1'b1, w[i]);
        checks++;
        if (frame_err !== 1'b0) begin
          errors++;
          $display("FAIL gap_abort_pulse cyc=%0d: got fe=%b need 0", cyc, frame_err);
        end
      end
      checks++;
      if (!(word_valid === 1'b1 && word_out === 12'h0F0)) begin
        errors++;
        $display("FAIL gap_recover: got wv=%b word=%h need 1 0f0", word_valid, word_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] w = 12'hB6D;
    logic [6:0]  n = 7'h55;
    logic        saw_fe = 1'b0;
    for (int i = 11; i >= 5; i--) step(1'b0, 1'b1, w[i]);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if ({word_out, word_valid, busy, frame_err, bit_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid: got word=%h wv=%b busy=%b fe=%b cnt=%0d need all 0",
               word_out, word_valid, busy, frame_err, bit_count);
    end
    for (int i = 4; i >= 0; i--) begin
      step(1'b0, 1'b1, w[i]);
      if (frame_err === 1'b1) saw_fe = 1'b1;
    end
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, 1'b1, n[i]);
      if (frame_err === 1'b1) saw_fe = 1'b1;
    end
    checks++;
    if (!(word_valid === 1'b1 && word_out === 12'h6D5 && !saw_fe)) begin
      errors++;
      $display("FAIL reset_mid_word: got wv=%b word=%h fe_seen=%b need 1 6d5 0", word_valid, word_out, saw_fe);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(1)));
      checks++;
      if ({frame_err, busy, bit_count} !== 6'h0) begin
        errors++;
        $display("FAIL idle cyc=%0d: got fe=%b busy=%b cnt=%0d need 0 0 0", cyc, frame_err, busy, bit_count);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      int r = $urandom_range(99);
      logic v;
      if (r < 70) v = 1'b1;
      else v = 1'b0;
      step(1'b0, v, 1'($urandom_range(1)));
      checks++;
      if ({word_valid, frame_err, busy, bit_count, word_out} !== {m_wv, m_fe, m_busy, m_cnt, m_word}) begin
        errors++;
        $display("FAIL random cyc=%0d: got wv=%b fe=%b busy=%b cnt=%0d word=%h need %b %b %b %0d %h",
                 cyc, word_valid, frame_err, busy, bit_count, word_out, m_wv, m_fe, m_busy, m_cnt, m_word);
      end
      // Occasionally insert a long idle run to exercise boundary gaps
      if (r < 5) begin
        int g = $urandom_range(GAP + 1, GAP - 1);
        for (int j = 0; j < g; j++) begin
          step(1'b0, 1'b0, 1'b0);
          checks++;
          if ({word_valid, frame_err, busy, bit_count, word_out} !== {m_wv, m_fe, m_busy, m_cnt, m_word}) begin
            errors++;
            $display("FAIL random_gap cyc=%0d: got wv=%b fe=%b busy=%b cnt=%0d word=%h need %b %b %b %0d %h",
                     cyc, word_valid, frame_err, busy, bit_count, word_out, m_wv, m_fe, m_busy, m_cnt, m_word);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    m_idle = 0;
    m_word = 12'h000;
    m_wv = 1'b0;
    m_fe = 1'b0;
    m_busy = 1'b0;
    m_cnt = 4'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap(GAP - 1);
    test_gap(GAP);
    test_reset_mid();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
